// File: rtl/hall_speed_meter.sv
// hall_speed_meter
//   Measures motor speed as valid hall-sensor transitions per fixed gate window.
//   Hall inputs are synchronized, each change of the synchronized code is checked
//   against the 1->3->2->6->4->5->1 forward sequence, valid steps are counted
//   (13-bit saturating) and the count is published once per window.
//
//   Optional feature: define HALL_SPEED_FILTER_EN to publish the two-window
//   average (current + previous) >> 1 instead of the raw window count.
//
// Parameters
//   GATE_CYCLES   clocks per measurement window (2..2^20)
//   SYNC_STAGES   hall synchronizer depth (2..4)
// Ports
//   i_clk          clock
//   i_reset        synchronous active-high reset
//   i_enable       measurement enable; low holds counters at 0
//   i_hall[2:0]    asynchronous hall sensors {C,B,A}
//   o_speed[12:0]  valid hall transitions in the last window
//   o_speed_valid  one-cycle strobe when o_speed is updated
//   o_direction    1 = forward, 0 = reverse (last valid step)
//   o_hall_fault   sticky flag: illegal code or non-adjacent jump seen
//   o_hall_state   synchronized hall code
module hall_speed_meter #(
    parameter int unsigned GATE_CYCLES = 100000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [2:0]  i_hall,
    output logic [12:0] o_speed,
    output logic        o_speed_valid,
    output logic        o_direction,
    output logic        o_hall_fault,
    output logic [2:0]  o_hall_state
);

    localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    logic [2:0]    sync_q [SYNC_STAGES];
    logic [2:0]    hall_s;
    logic [2:0]    prev_state;
    logic          prev_loaded;
    logic [12:0]   edge_cnt;
    logic [GW-1:0] gate_cnt;

    logic          legal;
    logic          changed;
    logic          step_fwd;
    logic          step_rev;
    logic          valid_edge;
    logic          bad_step;
    logic          terminal;
    logic [12:0]   win_total;

    // Successor of a code in the forward rotation; 0 for illegal codes.
    function automatic logic [2:0] fwd_next(input logic [2:0] code);
        case (code)
            3'd1:    fwd_next = 3'd3;
            3'd3:    fwd_next = 3'd2;
            3'd2:    fwd_next = 3'd6;
            3'd6:    fwd_next = 3'd4;
            3'd4:    fwd_next = 3'd5;
            3'd5:    fwd_next = 3'd1;
            default: fwd_next = 3'd0;
        endcase
    endfunction

    assign hall_s       = sync_q[SYNC_STAGES-1];
    assign o_hall_state = hall_s;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= i_hall;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        legal      = (hall_s != 3'b000) && (hall_s != 3'b111);
        changed    = prev_loaded && (hall_s != prev_state);
        step_fwd   = changed && legal && (hall_s == fwd_next(prev_state));
        step_rev   = changed && legal && (prev_state == fwd_next(hall_s));
        valid_edge = step_fwd || step_rev;
        bad_step   = changed && !valid_edge;
        terminal   = (gate_cnt == GATE_LAST);
        // Edge on the terminal cycle still belongs to the closing window.
        win_total  = (edge_cnt == '1) ? edge_cnt : edge_cnt + 13'(valid_edge);
    end

`ifdef HALL_SPEED_FILTER_EN
    logic [12:0] prev_win;
    logic [13:0] win_sum;
    assign win_sum = {1'b0, win_total} + {1'b0, prev_win};
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prev_state    <= '0;
            prev_loaded   <= 1'b0;
            edge_cnt      <= '0;
            gate_cnt      <= '0;
            o_speed       <= '0;
            o_speed_valid <= 1'b0;
            o_direction   <= 1'b0;
            o_hall_fault  <= 1'b0;
`ifdef HALL_SPEED_FILTER_EN
            prev_win      <= '0;
`endif
        end else if (!i_enable) begin
            prev_loaded   <= 1'b0;
            edge_cnt      <= '0;
            gate_cnt      <= '0;
            o_speed_valid <= 1'b0;
`ifdef HALL_SPEED_FILTER_EN
            prev_win      <= '0;
`endif
        end else begin
            // The reference code is only taken from a legal code, so the 000
            // left in the synchronizer by reset is never treated as a jump.
            // An illegal code leaves the last legal reference in place, so a
            // glitch back to the same code is neither counted nor re-flagged.
            if (!prev_loaded) begin
                if (legal) begin
                    prev_state  <= hall_s;
                    prev_loaded <= 1'b1;
                end
            end else if (changed && legal) begin
                prev_state <= hall_s;
            end

            if (step_fwd) begin
                o_direction <= 1'b1;
            end else if (step_rev) begin
                o_direction <= 1'b0;
            end

            if (bad_step) begin
                o_hall_fault <= 1'b1;
            end

            if (terminal) begin
`ifdef HALL_SPEED_FILTER_EN
                o_speed  <= win_sum[13:1];
                prev_win <= win_total;
`else
                o_speed  <= win_total;
`endif
                o_speed_valid <= 1'b1;
                edge_cnt      <= '0;
                gate_cnt      <= '0;
            end else begin
                o_speed_valid <= 1'b0;
                edge_cnt      <= win_total;
                gate_cnt      <= gate_cnt + GW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hall_speed_meter.sv
module tb_hall_speed_meter;

    localparam int G  = 100;
    localparam int S  = 2;
    localparam int G2 = 10000;

    logic        clk = 1'b0;
    logic        rst, en, en2;
    logic [2:0]  hall, hall2;
    logic [12:0] o_speed, o_speed2;
    logic        o_speed_valid, o_direction, o_hall_fault;
    logic        o_speed_valid2, o_direction2, o_hall_fault2;
    logic [2:0]  o_hall_state, o_hall_state2;

    hall_speed_meter #(.GATE_CYCLES(G), .SYNC_STAGES(S)) dut (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_hall(hall),
        .o_speed(o_speed), .o_speed_valid(o_speed_valid), .o_direction(o_direction),
        .o_hall_fault(o_hall_fault), .o_hall_state(o_hall_state)
    );

    hall_speed_meter #(.GATE_CYCLES(G2), .SYNC_STAGES(S)) dut_sat (
        .i_clk(clk), .i_reset(rst), .i_enable(en2), .i_hall(hall2),
        .o_speed(o_speed2), .o_speed_valid(o_speed_valid2), .o_direction(o_direction2),
        .o_hall_fault(o_hall_fault2), .o_hall_state(o_hall_state2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Forward rotation order; a code's position gives adjacency by modulo-6 distance.
    logic [2:0] seq [6];
    int         rot;

    // Reference model state (DUT with GATE_CYCLES=G)
    logic [2:0] hist [S];     // hist[0] = most recent sampled input
    logic [2:0] m_prev;
    logic       m_have, m_dir, m_fault, m_valid;
    int         m_cnt, m_gate, m_speed, m_prevwin;

    function automatic int pos(input logic [2:0] c);
        for (int k = 0; k < 6; k++) if (seq[k] == c) return k;
        return -1;
    endfunction

    function automatic logic [18:0] obs_vec();
        return {o_speed_valid, o_direction, o_hall_fault, o_hall_state, o_speed};
    endfunction

    function automatic logic [18:0] exp_vec();
        return {m_valid, m_dir, m_fault, hist[S-1], 13'(m_speed)};
    endfunction

    // Drive one clock and advance the reference model by one clock.
    task automatic tick(input logic [2:0] h, input logic e, input logic r);
        logic [2:0] s;
        int d, total;
        bit edge_ok;
        rst = r; en = e; hall = h;
        @(posedge clk);
        s = hist[S-1];
        for (int k = S-1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = h;
        if (r) begin
            for (int k = 0; k < S; k++) hist[k] = '0;
            m_prev = '0; m_have = 0; m_dir = 0; m_fault = 0; m_valid = 0;
            m_cnt = 0; m_gate = 0; m_speed = 0; m_prevwin = 0;
        end else if (!e) begin
            m_have = 0; m_cnt = 0; m_gate = 0; m_valid = 0; m_prevwin = 0;
        end else begin
            edge_ok = 0;
            if (!m_have) begin
                if (pos(s) >= 0) begin m_prev = s; m_have = 1; end
            end else if (s != m_prev) begin
                if (pos(s) < 0) m_fault = 1;
                else begin
                    d = (pos(s) - pos(m_prev) + 6) % 6;
                    if (d == 1) begin edge_ok = 1; m_dir = 1; end
                    else if (d == 5) begin edge_ok = 1; m_dir = 0; end
                    else m_fault = 1;
                    m_prev = s;
                end
            end
            total = m_cnt + int'(edge_ok);
            if (total > 8191) total = 8191;
            if (m_gate == G - 1) begin
`ifdef HALL_SPEED_FILTER_EN
                m_speed = (total + m_prevwin) / 2;
`else
                m_speed = total;
`endif
                m_prevwin = total;
                m_valid = 1; m_cnt = 0; m_gate = 0;
            end else begin
                m_valid = 0; m_cnt = total; m_gate++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(3'd0, 1'b0, 1'b1);
        checks++; if (o_speed !== 13'd0) begin errors++; $display("FAIL reset_speed got=%0d exp=0", o_speed); end
        checks++; if (o_speed_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_speed_valid); end
        checks++; if (o_direction !== 1'b0) begin errors++; $display("FAIL reset_dir got=%b exp=0", o_direction); end
        checks++; if (o_hall_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", o_hall_fault); end
        checks++; if (o_hall_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", o_hall_state); end
    endtask

    task automatic test_forward();
        int nstr = 0, last = -1;
        rot = 0;
        for (int i = 0; i < 450; i++) begin
            if (i % 10 == 9) rot = (rot + 1) % 6;
            tick(seq[rot], 1'b1, 1'b0);
            checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL fwd_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            if (o_speed_valid) begin
                nstr++;
                if (last >= 0) begin
                    checks++; if (cyc - last != G) begin errors++; $display("FAIL fwd_period got=%0d exp=%0d", cyc - last, G); end
                end
                last = cyc;
                if (nstr >= 3) begin
                    checks++; if (o_speed !== 13'd10) begin errors++; $display("FAIL fwd_speed got=%0d exp=10", o_speed); end
                end
            end
        end
        checks++; if (nstr < 4) begin errors++; $display("FAIL fwd_strobes got=%0d exp>=4", nstr); end
        checks++; if (o_direction !== 1'b1) begin errors++; $display("FAIL fwd_dir got=%b exp=1", o_direction); end
        checks++; if (o_hall_fault !== 1'b0) begin errors++; $display("FAIL fwd_fault got=%b exp=0", o_hall_fault); end
    endtask

    task automatic test_reverse();
        int nstr = 0;
        for (int i = 0; i < 500; i++) begin
            if (i % 20 == 19) rot = (rot + 5) % 6;
            tick(seq[rot], 1'b1, 1'b0);
            checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL rev_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            if (o_speed_valid) begin
                nstr++;
                if (nstr >= 3) begin
                    checks++; if (o_speed !== 13'd5) begin errors++; $display("FAIL rev_speed got=%0d exp=5", o_speed); end
                end
            end
        end
        checks++; if (o_direction !== 1'b0) begin errors++; $display("FAIL rev_dir got=%b exp=0", o_direction); end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 300; i++) begin
            if (i % 10 == 9) rot = (rot + 1) % 6;
            tick((i >= 40 && i < 45) ? 3'd7 : seq[rot], 1'b1, 1'b0);
            checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL ill_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
        end
        checks++; if (o_hall_fault !== 1'b1) begin errors++; $display("FAIL ill_fault got=%b exp=1", o_hall_fault); end
        for (int i = 0; i < 10; i++) begin
            tick(seq[rot], 1'b0, 1'b0);
            checks++; if (o_speed_valid !== 1'b0) begin errors++; $display("FAIL ill_dis_valid got=%b exp=0", o_speed_valid); end
        end
        checks++; if (o_hall_fault !== 1'b1) begin errors++; $display("FAIL ill_fault_hold got=%b exp=1", o_hall_fault); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen;
        for (int i = 0; i < 200 && m_gate != 50; i++) begin
            if (i % 10 == 9) rot = (rot + 1) % 6;
            tick(seq[rot], 1'b1, 1'b0);
        end
        checks++; if (m_gate != 50) begin errors++; $display("FAIL mid_reach_gate got=%0d exp=50", m_gate); end
        tick(seq[rot], 1'b1, 1'b1);
        checks++; if ({o_speed, o_speed_valid, o_direction, o_hall_fault, o_hall_state} !== 19'd0)
            begin errors++; $display("FAIL mid_reset_outs got=%h exp=0", {o_speed, o_speed_valid, o_direction, o_hall_fault, o_hall_state}); end
        for (int i = 0; i < 30; i++) begin
            tick(seq[rot], 1'b0, 1'b0);
            checks++; if (o_speed_valid !== 1'b0) begin errors++; $display("FAIL mid_dis_valid got=%b exp=0", o_speed_valid); end
        end
        n = 0; seen = 0;
        while (!seen && n < 300) begin
            tick(seq[rot], 1'b1, 1'b0);
            n++;
            seen = o_speed_valid;
            checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL mid_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
        end
        checks++; if (!seen || n != G) begin errors++; $display("FAIL mid_first_strobe got=%0d exp=%0d", n, G); end
    endtask

    task automatic test_filter();
        int n = 0;
        tick(seq[rot], 1'b0, 1'b1);
        while (n < 300) begin
            tick(seq[rot], 1'b1, 1'b0);
            n++;
            if (o_speed_valid) break;
        end
        checks++; if (o_speed_valid !== 1'b1 || o_speed !== 13'd0) begin errors++; $display("FAIL filt_w0 got=%0d/%b exp=0/1", o_speed, o_speed_valid); end
        for (int w = 0; w < 2; w++) begin
            for (int j = 0; j < G; j++) begin
                if ((w == 0 && j % 10 == 5) || (w == 1 && j % 5 == 2)) rot = (rot + 1) % 6;
                tick(seq[rot], 1'b1, 1'b0);
                checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL filt_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            end
`ifdef HALL_SPEED_FILTER_EN
            checks++; if (o_speed_valid !== 1'b1 || o_speed !== ((w == 0) ? 13'd5 : 13'd15))
                begin errors++; $display("FAIL filt_win%0d got=%0d exp=%0d", w, o_speed, (w == 0) ? 5 : 15); end
`else
            checks++; if (o_speed_valid !== 1'b1 || o_speed !== ((w == 0) ? 13'd10 : 13'd20))
                begin errors++; $display("FAIL filt_win%0d got=%0d exp=%0d", w, o_speed, (w == 0) ? 10 : 20); end
`endif
        end
    endtask

    task automatic test_random();
        logic [2:0] h = seq[rot];
        logic e = 1'b1, r;
        int x;
        for (int i = 0; i < 2500; i++) begin
            x = $urandom_range(0, 99);
            if (x < 20) begin rot = (rot + 1) % 6; h = seq[rot]; end
            else if (x < 30) begin rot = (rot + 5) % 6; h = seq[rot]; end
            else if (x < 33) begin
                h = 3'($urandom_range(0, 7));
                if (pos(h) >= 0) rot = pos(h);
            end
            if ($urandom_range(0, 149) == 0) e = !e;
            r = ($urandom_range(0, 799) == 0);
            tick(h, e, r);
            checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL rand_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
        end
    endtask

    task automatic test_saturate();
        int n = 0, nstr = 0, last = 0, r2 = 0;
        tick(seq[rot], 1'b0, 1'b1);
        en2 = 1'b1;
        while (nstr < 2 && n < 2 * G2 + 500) begin
            r2 = (r2 + 1) % 6;
            hall2 = seq[r2];
            tick(seq[rot], 1'b0, 1'b0);
            n++;
            if (o_speed_valid2) begin
                nstr++;
                if (nstr == 1) begin
                    checks++; if (n != G2) begin errors++; $display("FAIL sat_first_strobe got=%0d exp=%0d", n, G2); end
`ifdef HALL_SPEED_FILTER_EN
                    checks++; if (o_speed2 !== 13'd4095) begin errors++; $display("FAIL sat_w1 got=%0d exp=4095", o_speed2); end
`else
                    checks++; if (o_speed2 !== 13'd8191) begin errors++; $display("FAIL sat_w1 got=%0d exp=8191", o_speed2); end
`endif
                end else begin
                    checks++; if (n - last != G2) begin errors++; $display("FAIL sat_period got=%0d exp=%0d", n - last, G2); end
                    checks++; if (o_speed2 !== 13'd8191) begin errors++; $display("FAIL sat_w2 got=%0d exp=8191", o_speed2); end
                end
                last = n;
            end
        end
        checks++; if (nstr != 2) begin errors++; $display("FAIL sat_strobes got=%0d exp=2", nstr); end
        checks++; if (o_direction2 !== 1'b1 || o_hall_fault2 !== 1'b0 || pos(o_hall_state2) < 0)
            begin errors++; $display("FAIL sat_status got=%b%b%0d exp=1,0,legal", o_direction2, o_hall_fault2, o_hall_state2); end
        en2 = 1'b0;
    endtask

    initial begin
        seq[0] = 3'd1; seq[1] = 3'd3; seq[2] = 3'd2;
        seq[3] = 3'd6; seq[4] = 3'd4; seq[5] = 3'd5;
        rot = 0;
        for (int k = 0; k < S; k++) hist[k] = '0;
        m_prev = '0; m_have = 0; m_dir = 0; m_fault = 0; m_valid = 0;
        m_cnt = 0; m_gate = 0; m_speed = 0; m_prevwin = 0;
        rst = 1'b1; en = 1'b0; hall = 3'd0; en2 = 1'b0; hall2 = 3'd1;
        test_reset();
        test_forward();
        test_reverse();
        test_illegal();
        test_reset_mid();
        test_filter();
        test_random();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
